// File: rtl/lcd_seq.sv
// HD44780 character-LCD sequencer: autonomous power-up/init, then one command
// or data byte per valid/ready handshake, with EN pulse timing and busy waits.
module lcd_seq #(
    parameter int T_SETUP = 2,
    parameter int T_EN    = 25,
    parameter int T_CMD   = 2000,
    parameter int T_CLEAR = 80000,
    parameter int T_PWRUP = 2000000,
    parameter int CNT_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_rs,
    input  logic [7:0]  req_data,
    output logic        req_ready,
    input  logic        reinit,
    output logic        init_done,
    output logic [31:0] o_lcd
);

    typedef enum logic [2:0] {
        S_PWRUP,
        S_LOAD,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_IDLE
    } state_t;

    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(T_CLEAR - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic             en_q;
    logic             rs_q;
    logic [7:0]       data_q;
    logic             init_done_q;
    logic             long_wait;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    // Clear and return-home need the long busy wait; data writes never do.
    assign long_wait = ~rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

    assign req_ready = (state_q == S_IDLE) && init_done_q && ~reinit;
    assign init_done = init_done_q;
    // The ON bit follows reset directly so it is already high in the first cycle out of reset.
    assign o_lcd     = {~rst, 20'd0, 1'b0, rs_q, en_q, data_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PWRUP;
            cnt_q       <= PWRUP_LD;
            idx_q       <= 2'd0;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            init_done_q <= 1'b0;
        end else begin
            // NOTE: this default decrement is overridden by any later reload in the case
            // below; with non-blocking assignments the last one in program order wins.
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);

            case (state_q)
                S_PWRUP: begin
                    if (cnt_q == '0) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    data_q  <= init_cmd(idx_q);
                    rs_q    <= 1'b0;
                    cnt_q   <= SETUP_LD;
                    state_q <= S_SETUP;
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b1;
                        cnt_q   <= EN_LD;
                        state_q <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == '0) begin
                        en_q    <= 1'b0;
                        cnt_q   <= long_wait ? CLEAR_LD : CMD_LD;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        // Before init_done is set, every byte in flight comes from the init list.
                        if (!init_done_q && idx_q != 2'd3) begin
                            idx_q   <= idx_q + 2'd1;
                            state_q <= S_LOAD;
                        end else begin
                            init_done_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end
                    end
                end
                S_IDLE: begin
                    if (reinit) begin
                        init_done_q <= 1'b0;
                        idx_q       <= 2'd0;
                        state_q     <= S_LOAD;
                    end else if (req_valid && init_done_q) begin
                        data_q  <= req_data;
                        rs_q    <= req_rs;
                        cnt_q   <= SETUP_LD;
                        state_q <= S_SETUP;
                    end
                end
                default: state_q <= S_PWRUP;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_seq.sv
// Self-checking bench for lcd_seq: a scoreboard of expected EN-pulse bytes plus
// per-scenario cycle-timing checks, using short timing parameters.
module tb_lcd_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_rs;
    logic [7:0]  req_data;
    logic        req_ready;
    logic        reinit;
    logic        init_done;
    logic [31:0] o_lcd;

    int n_cmp = 0;
    int n_mis = 0;

    logic [8:0] exp_q[$];
    logic [8:0] last_byte;

    lcd_seq #(
        .T_SETUP(2), .T_EN(3), .T_CMD(5), .T_CLEAR(20), .T_PWRUP(10), .CNT_W(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_rs   (req_rs),
        .req_data (req_data),
        .req_ready(req_ready),
        .reinit   (reinit),
        .init_done(init_done),
        .o_lcd    (o_lcd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: each EN rising edge pops the byte expected on the bus,
    // and each falling edge checks the pulse lasted T_EN cycles.
    logic en_prev = 1'b0;
    int   en_len  = 0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            en_prev = 1'b0;
            en_len  = 0;
        end else begin
            if (o_lcd[8] && !en_prev) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL sb_unexpected_pulse: got rs/data=%h, expected no pulse", {o_lcd[9], o_lcd[7:0]});
                end else begin
                    e = exp_q.pop_front();
                    if ({o_lcd[9], o_lcd[7:0]} !== e || o_lcd[10] !== 1'b0) begin
                        n_mis++;
                        $display("FAIL sb_pulse_byte: got rs/data=%h rw=%b, expected %h rw=0",
                                 {o_lcd[9], o_lcd[7:0]}, o_lcd[10], e);
                    end
                end
                en_len = 1;
            end else if (o_lcd[8]) begin
                en_len++;
            end else if (en_prev) begin
                n_cmp++;
                if (en_len !== 3) begin
                    n_mis++;
                    $display("FAIL sb_en_width: got %0d cycles, expected 3", en_len);
                end
            end
            en_prev = o_lcd[8];
        end
    end

    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    // Walks an init sequence from cycle index n0; returns the first cycle with
    // init_done or req_ready high, whether EN rose in cycles 0..10, and the
    // gap from the 0x01 pulse falling to the next pulse rising.
    task automatic measure_init(input int n0, output int ready_cyc, output bit en_early,
                                output int clear_gap, output bit on_ok);
        int fall_cyc = -1;
        bit pe = 1'b0;
        ready_cyc = -1;
        en_early  = 1'b0;
        clear_gap = -1;
        on_ok     = 1'b1;
        for (int n = n0; n < 300; n++) begin
            @(negedge clk);
            if (o_lcd[31] !== 1'b1) on_ok = 1'b0;
            if (n <= 10 && o_lcd[8] !== 1'b0) en_early = 1'b1;
            if (pe && !o_lcd[8] && o_lcd[7:0] == 8'h01) fall_cyc = n;
            if (!pe && o_lcd[8] && fall_cyc >= 0 && clear_gap < 0) clear_gap = n - fall_cyc;
            if (init_done || req_ready) begin
                ready_cyc = n;
                break;
            end
            pe = o_lcd[8];
        end
    endtask

    task automatic wait_ready(input int budget, output int n_out);
        n_out = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready) begin
                n_out = i;
                break;
            end
        end
    endtask

    // Called at a negedge with req_ready high; returns cycles from accept to ready.
    task automatic send_byte(input logic rs, input logic [7:0] data, output int rdy);
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = data;
        exp_q.push_back({rs, data});
        last_byte = {rs, data};
        @(posedge clk);
        #1 req_valid = 1'b0;
        rdy = -1;
        for (int n = 1; n < 100; n++) begin
            @(negedge clk);
            if (req_ready) begin
                rdy = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int rc, gap;
        bit early, on_ok;
        rst = 1'b1; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00; reinit = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (o_lcd !== 32'h0 || req_ready !== 1'b0 || init_done !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_state: o_lcd=%h ready=%b done=%b, expected 0/0/0", o_lcd, req_ready, init_done);
        end
        push_init();
        @(posedge clk);
        #1 rst = 1'b0;
        measure_init(0, rc, early, gap, on_ok);
        n_cmp++;
        if (early !== 1'b0) begin n_mis++; $display("FAIL pwrup_en_low: EN high by cycle 10, expected low"); end
        n_cmp++;
        if (on_ok !== 1'b1) begin n_mis++; $display("FAIL pwrup_on_bit: o_lcd[31] dropped, expected 1"); end
        n_cmp++;
        if (gap !== 23) begin n_mis++; $display("FAIL pwrup_clear_gap: got %0d, expected 23", gap); end
        n_cmp++;
        if (rc !== 69 || init_done !== 1'b1 || req_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL pwrup_ready: cycle=%0d done=%b ready=%b, expected 69/1/1", rc, init_done, req_ready);
        end
        last_byte = {1'b0, 8'h06};
    endtask

    task automatic test_data_write();
        int first_en = -1, last_en = -1, rdy = -1, n2;
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h41;
        exp_q.push_back({1'b1, 8'h41});
        @(posedge clk);
        #1 req_data = 8'h42;
        exp_q.push_back({1'b1, 8'h42});
        for (int n = 1; n < 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                n_cmp++;
                if (o_lcd[7:0] !== 8'h41 || o_lcd[9] !== 1'b1 || o_lcd[8] !== 1'b0) begin
                    n_mis++;
                    $display("FAIL write_latch: data=%h rs=%b en=%b, expected 41/1/0", o_lcd[7:0], o_lcd[9], o_lcd[8]);
                end
            end
            if (o_lcd[8] && first_en < 0) first_en = n;
            if (o_lcd[8]) last_en = n;
            if (req_ready) begin rdy = n; break; end
        end
        n_cmp++;
        if (first_en !== 3 || last_en !== 5) begin
            n_mis++;
            $display("FAIL write_en_window: got %0d..%0d, expected 3..5", first_en, last_en);
        end
        n_cmp++;
        if (rdy !== 11) begin n_mis++; $display("FAIL write_ready: got %0d, expected 11", rdy); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_lcd[7:0] !== 8'h42 || o_lcd[9] !== 1'b1 || req_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL write_second: data=%h rs=%b ready=%b, expected 42/1/0", o_lcd[7:0], o_lcd[9], req_ready);
        end
        last_byte = {1'b1, 8'h42};
        wait_ready(40, n2);
        n_cmp++;
        if (n2 !== 9) begin n_mis++; $display("FAIL write_second_ready: got %0d, expected 9", n2); end
    endtask

    task automatic test_clear_timing();
        logic [8:0] bytes [6] = '{{1'b0, 8'h01}, {1'b0, 8'h80}, {1'b0, 8'h02},
                                  {1'b1, 8'h01}, {1'b0, 8'h03}, {1'b0, 8'h04}};
        int exp_rdy [6] = '{26, 11, 26, 11, 26, 11};
        int rdy;
        for (int i = 0; i < 6; i++) begin
            send_byte(bytes[i][8], bytes[i][7:0], rdy);
            n_cmp++;
            if (rdy !== exp_rdy[i]) begin
                n_mis++;
                $display("FAIL clear_timing[%0d] rs/data=%h: ready after %0d, expected %0d", i, bytes[i], rdy, exp_rdy[i]);
            end
        end
    endtask

    task automatic test_reinit();
        int rc, gap, n2;
        bit early, on_ok;
        reinit = 1'b1; req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
        push_init();
        exp_q.push_back({1'b1, 8'h55});
        @(posedge clk);
        #1 reinit = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (init_done !== 1'b0 || req_ready !== 1'b0 || {o_lcd[9], o_lcd[7:0]} !== last_byte) begin
            n_mis++;
            $display("FAIL reinit_reject: done=%b ready=%b rs/data=%h, expected 0/0/%h",
                     init_done, req_ready, {o_lcd[9], o_lcd[7:0]}, last_byte);
        end
        measure_init(1, rc, early, gap, on_ok);
        n_cmp++;
        if (gap !== 23) begin n_mis++; $display("FAIL reinit_clear_gap: got %0d, expected 23", gap); end
        n_cmp++;
        if (rc !== 59 || init_done !== 1'b1 || req_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reinit_ready: cycle=%0d done=%b ready=%b, expected 59/1/1", rc, init_done, req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_lcd[7:0] !== 8'h55 || o_lcd[9] !== 1'b1) begin
            n_mis++;
            $display("FAIL reinit_held_req: data=%h rs=%b, expected 55/1", o_lcd[7:0], o_lcd[9]);
        end
        last_byte = {1'b1, 8'h55};
        wait_ready(40, n2);
        n_cmp++;
        if (n2 !== 9) begin n_mis++; $display("FAIL reinit_held_ready: got %0d, expected 9", n2); end
    endtask

    task automatic test_back_pressure();
        int rdy = -1;
        bit bad_data = 1'b0, bad_done = 1'b0;
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h30;
        exp_q.push_back({1'b1, 8'h30});
        @(posedge clk);
        for (int n = 1; n < 40; n++) begin
            @(negedge clk);
            if (o_lcd[7:0] !== 8'h30 || o_lcd[9] !== 1'b1) bad_data = 1'b1;
            if (init_done !== 1'b1) bad_done = 1'b1;
            if (req_ready) begin
                rdy = n;
                req_valid = 1'b0;
                reinit = 1'b0;
                break;
            end
            req_valid = 1'($urandom_range(0, 1));
            req_rs    = 1'($urandom_range(0, 1));
            req_data  = 8'($urandom_range(0, 255));
            reinit    = (n == 7);
        end
        n_cmp++;
        if (bad_data) begin n_mis++; $display("FAIL bp_data_stable: bus changed while busy, expected 30 held"); end
        n_cmp++;
        if (bad_done) begin n_mis++; $display("FAIL bp_reinit_ignored: init_done dropped, expected 1"); end
        n_cmp++;
        if (rdy !== 11) begin n_mis++; $display("FAIL bp_ready: got %0d, expected 11", rdy); end
        last_byte = {1'b1, 8'h30};
    endtask

    task automatic test_reset_mid_pulse();
        int rc, gap, seen = -1;
        bit early, on_ok;
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h77;
        exp_q.push_back({1'b1, 8'h77});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n < 20; n++) begin
            @(negedge clk);
            if (o_lcd[8]) begin seen = n; break; end
        end
        n_cmp++;
        if (seen !== 3) begin n_mis++; $display("FAIL midrst_pulse_seen: EN at %0d, expected 3", seen); end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (o_lcd !== 32'h0 || init_done !== 1'b0 || req_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL midrst_state: o_lcd=%h done=%b ready=%b, expected 0/0/0", o_lcd, init_done, req_ready);
        end
        exp_q.delete();
        push_init();
        @(posedge clk);
        #1 rst = 1'b0;
        measure_init(0, rc, early, gap, on_ok);
        n_cmp++;
        if (early !== 1'b0 || on_ok !== 1'b1) begin
            n_mis++;
            $display("FAIL midrst_pwrup: early_en=%b on_ok=%b, expected 0/1", early, on_ok);
        end
        n_cmp++;
        if (rc !== 69 || init_done !== 1'b1 || req_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL midrst_ready: cycle=%0d done=%b ready=%b, expected 69/1/1", rc, init_done, req_ready);
        end
    endtask

    task automatic test_scoreboard_drained();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_mis++;
            $display("FAIL sb_drained: %0d pulses outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_data_write();
        test_clear_timing();
        test_reinit();
        test_back_pressure();
        test_reset_mid_pulse();
        test_scoreboard_drained();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lcd_seq.md
Name: lcd_seq

Overview:
- Hardware sequencer for the HD44780-style character LCD behind the output peripheral's LCD register.
- Replaces software bit-banging: runs the power-up/init sequence autonomously, then accepts one command or data byte per valid/ready handshake.
- Generates RS/RW/EN timing and per-instruction busy waits from cycle-count parameters.
- Drives a 32-bit word in the same bit layout as the LCD output register, so it can be muxed onto the pins.

Parameters:
- T_SETUP, 2, cycles RS/DATA are stable before EN rises (≥1).
- T_EN, 25, cycles EN is held high (≥1).
- T_CMD, 2000, post-pulse wait for ordinary instructions and data writes (≥1).
- T_CLEAR, 80000, post-pulse wait for clear (0x01) and return-home (0x02/0x03) instructions.
- T_PWRUP, 2000000, wait after reset before the first init command (≥1).
- CNT_W, 32, width of the single shared down-counter; must hold the largest parameter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  requester has a byte to send
- req_rs  in  1  0 = instruction, 1 = data
- req_data  in  8  byte to send
- req_ready  out  1  byte accepted on the clk edge where req_valid & req_ready
- reinit  in  1  single-cycle pulse; re-runs the init command list (no power-up wait)
- init_done  out  1  init sequence completed
- o_lcd  out  32  [7:0] DATA, [8] EN, [9] RS, [10] RW, [31] ON, others 0

Behaviour:
- Reset (rst=1 at a clk edge) applies from any state, including mid-pulse:
  - state=PWRUP, counter=T_PWRUP, o_lcd=0, req_ready=0, init_done=0, init index=0.
  - EN is therefore low in the cycle after reset.
- Cycle 0 is the first cycle with rst low. From cycle 0 onwards, o_lcd[31]=1 permanently until the next reset.
- RW (o_lcd[10]) is always 0; the block never reads the LCD.
- States and transitions:
  - PWRUP: hold for T_PWRUP cycles, then go to LOAD.
  - LOAD: one cycle. Latch the init-list entry (RS=0) onto DATA/RS. Go to SETUP.
  - SETUP: hold for T_SETUP cycles with EN=0. Go to PULSE.
  - PULSE: hold for T_EN cycles with EN=1. Go to WAIT.
  - WAIT: EN=0. Hold for Tw cycles, where Tw = T_CLEAR if RS=0 and DATA ∈ {0x01,0x02,0x03}, else T_CMD.
    - If an init command is in progress and it is not the last one: advance the init index, go to LOAD.
    - Otherwise: go to IDLE.
  - IDLE: hold DATA/RS from the last byte, EN=0.
- Init list, in order: 0x38 (8-bit, 2-line), 0x0C (display on), 0x01 (clear), 0x06 (entry increment).
- init_done is set on entry to IDLE after the last init command. It is cleared on reset or on an accepted reinit.
- req_ready = (state==IDLE) & init_done & ~reinit. It is combinational from the state register and reinit.
- Handshake:
  - req_valid & req_ready at edge k captures req_rs and req_data.
  - New DATA/RS are visible in cycle k+1 (SETUP).
  - EN rises at cycle k+1+T_SETUP and falls at k+1+T_SETUP+T_EN.
  - req_ready returns at cycle k+1+T_SETUP+T_EN+Tw.
  - No internal queue; requesters must hold req_valid until accepted.
- req_valid while not ready: ignored; no state change.
- reinit:
  - Honoured only in IDLE; it beats a simultaneous req_valid, which is not accepted.
  - On accept: init_done=0, init index=0, next state LOAD.
  - reinit in any other state is ignored.
- Latched DATA/RS are never modified during SETUP/PULSE/WAIT.
- Counter:
  - Loaded with (duration−1) on state entry, decremented each cycle.
  - The state exits when the counter is 0.
  - No wrap-around: the counter is never decremented below 0.
- Counts below assume test params T_SETUP=2, T_EN=3, T_CMD=5, T_CLEAR=20, T_PWRUP=10:
  - Each non-clear init command occupies 1+2+3+5 = 11 cycles.
  - The clear command occupies 26 cycles.
  - init_done=1 and req_ready=1 first in cycle 10+11+11+26+11 = 69.

Test Plan:
- Power-up (test params, rst high 3 cycles then low):
  - o_lcd[8]=0 through cycle 10.
  - EN pulses occur with DATA=0x38, 0x0C, 0x01, 0x06 in order, RS=0, RW=0.
  - The 0x01 wait is 20 cycles.
  - init_done=1 and req_ready=1 at cycle 69, not before.
- Data write after init:
  - req_valid=1, req_rs=1, req_data=0x41 accepted at edge k.
  - o_lcd[7:0]=0x41 and o_lcd[9]=1 from k+1; EN high in cycles k+3..k+5.
  - req_ready=0 until k+11.
  - A second byte 0x42 held valid is accepted at k+11.
- Clear timing: req_rs=0, req_data=0x01 → req_ready returns at k+26; req_data=0x80 → returns at k+11.
- Simultaneous reinit and req_valid in IDLE:
  - The request is not accepted; init_done drops next cycle.
  - The 4-command list replays without the 10-cycle power-up (59 cycles), then the held request is accepted.
- Reset mid-pulse: rst asserted during PULSE → o_lcd=0 next cycle, and the full 69-cycle power-up repeats.
- Back-pressure: req_valid toggling during WAIT with changing req_data → o_lcd[7:0] is unchanged until the next accept.
